// File: rtl/instr_buffer.sv
// instr_buffer: fetch-to-decode decoupling queue with slot compaction, back-pressure and flush
package instr_buffer_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
        logic [4:0]  excp_num;
        logic [5:0]  ftq_id;
        logic        bpu_taken;
        logic [31:0] bpu_target;
        logic        is_last_in_block;
    } instr_buffer_info_t;
endpackage

module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int ENQ_WIDTH = 4,
    parameter int DEQ_WIDTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  instr_buffer_info_t frontend_instr_i [ENQ_WIDTH],
    output logic               frontend_stallreq_o,
    input  logic [DEQ_WIDTH-1:0] backend_accept_i,
    output instr_buffer_info_t backend_instr_o [DEQ_WIDTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    instr_buffer_info_t mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [CW-1:0] enq_num, enq_amt, deq_num;
    logic [PW-1:0] off [ENQ_WIDTH];
    logic          enq;

    // stall looks only at registered occupancy, so it never depends on inputs
    assign frontend_stallreq_o = count > CW'(DEPTH - ENQ_WIDTH);
    assign enq                 = !frontend_stallreq_o && !flush;
    assign enq_amt             = enq ? enq_num : '0;

    // compaction: each valid slot lands at tail plus the number of valid slots before it
    always_comb begin
        enq_num = '0;
        for (int j = 0; j < ENQ_WIDTH; j++) begin
            off[j]  = enq_num[PW-1:0];
            enq_num = enq_num + CW'(frontend_instr_i[j].valid);
        end
    end

    // present oldest entries, masked by occupancy and flush; count accepted prefix
    always_comb begin
        deq_num = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
            backend_instr_o[i] = (!flush && CW'(i) < count) ? mem[head + PW'(i)] : '0;
            deq_num = deq_num + CW'(backend_accept_i[i] && backend_instr_o[i].valid);
        end
    end

    // pointer and occupancy update; flush wins over same-cycle enqueue/dequeue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_num[PW-1:0];
            tail  <= tail + enq_amt[PW-1:0];
            count <= count + enq_amt - deq_num;
        end
    end

    // payload storage; stale entries are hidden by count so they are never cleared
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int j = 0; j < ENQ_WIDTH; j++) begin
                if (frontend_instr_i[j].valid) mem[tail + off[j]] <= frontend_instr_i[j];
            end
        end
    end

    // decoder accepts must form a contiguous run starting at slot 0
    accept_prefix: assert property (@(posedge clk) disable iff (rst)
        (backend_accept_i & (backend_accept_i + DEQ_WIDTH'(1))) == '0);
endmodule

// File: doc/instr_buffer.md
# instr_buffer

Decoupling queue between the instruction fetch unit and the decoder. Each cycle it accepts a fetch group of up to `ENQ_WIDTH` `instr_buffer_info_t` entries and presents the oldest `DEQ_WIDTH` (= `DECODE_WIDTH`) entries in program order to the ID stage. It absorbs fetch/decode rate mismatch, back-pressures the frontend when space is short, and is emptied by backend flush.

## Interface
Parameters:
- `DEPTH`, 8: number of entries. Must be a power of 2 and ≥ `ENQ_WIDTH + DEQ_WIDTH`.
- `ENQ_WIDTH`, 4: frontend slots per cycle.
- `DEQ_WIDTH`, 2: decoder slots per cycle (`DECODE_WIDTH`).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: backend redirect. Empties the buffer.
- `frontend_instr_i` in `ENQ_WIDTH` x `instr_buffer_info_t`: fetch group. Per-slot `.valid`.
- `frontend_stallreq_o` out 1: frontend must hold `frontend_instr_i` this cycle.
- `backend_accept_i` in `DEQ_WIDTH`: decoder consumed output slot i.
- `backend_instr_o` out `DEQ_WIDTH` x `instr_buffer_info_t`: oldest entries. Slot 0 is the oldest.

## Operation
- Storage: `DEPTH` registered entries, `head`/`tail` pointers of `$clog2(DEPTH)` bits, and `count` of `$clog2(DEPTH)+1` bits.
- Pointer arithmetic is modulo `DEPTH`. Pointers wrap naturally with no special case.
- **Stall:** `frontend_stallreq_o` = (`DEPTH - count < ENQ_WIDTH`). It is computed from registered `count` only. It is conservative: it ignores same-cycle dequeue.
- **Enqueue:** performed when `stallreq == 0` and `flush == 0`.
  - Valid input slots are compacted in slot order into `tail`, `tail+1`, …. Invalid slots are skipped, so mask 0101 writes 2 entries.
  - `enq_num` = popcount(valid). `tail += enq_num`.
  - If stalled, the input is ignored and the frontend holds it.
- **Output:**
  - `backend_instr_o[i]` = entry[`head+i`] when `i < count`, else all-zero with `valid = 0`.
  - Output is a combinational read of registered state.
  - While `flush == 1`, every output `valid` is forced to 0.
- **Dequeue:**
  - `deq_num` = number of i with `backend_accept_i[i] && backend_instr_o[i].valid`.
  - Accept must be a prefix: `accept[1]` without `accept[0]` is illegal and is flagged by an assertion.
  - `head += deq_num`.
- **Count:** simultaneous enqueue and dequeue give `count_next = count + enq_num - deq_num`. This never overflows, because of the stall rule.
- **Flush:** `head`, `tail` and `count` become 0 next cycle. Same-cycle enqueue and dequeue are discarded. Entry contents need not be cleared; they are masked by `count`.
- **Reset (async):** `head = tail = count = 0`. All output `valid` = 0, `frontend_stallreq_o` = 0. Reset takes effect immediately, mid-operation included.
- Entry payload fields (`excp`, `excp_num`, `ftq_id`, BPU bits, `is_last_in_block`) are stored and returned bit-exact.

## Timing
- Enqueue-to-output latency: 1 cycle. An entry written at edge N is visible on `backend_instr_o` after edge N.
- No bypass from input to output while the buffer is empty.
- Dequeue takes effect at the clock edge. The next oldest entries appear in the following cycle.
- `frontend_stallreq_o` changes only after a clock edge or reset. It has no combinational path from any input.
- Throughput: sustained `DEQ_WIDTH` per cycle while `count ≥ DEQ_WIDTH`.
- Flush has priority over enqueue and dequeue in the same cycle.

## Test plan
- **Basic flow:** after reset, enqueue 4 valid entries with pc `0x1c000000`/`04`/`08`/`0c`.
  - Next cycle: out0 = `0x1c000000`, out1 = `0x1c000004`, both valid.
  - Accept 2: next cycle out0 = `0x1c000008`, out1 = `0x1c00000c`. Accept 2 again: both outputs invalid, count 0.
- **Back-pressure:** two full groups with no accept give count 8 and `stallreq = 1`.
  - Accept 2: count 6, stall still 1.
  - Accept 2: count 4, stall 0. A group held during the stall is enqueued exactly once, in order.
- **Sparse enqueue:** mask 0101 with pcs A/–/C/–.
  - Next cycle: out0 = A, out1 = C, count 2. `excp`/`ftq_id` fields match the input exactly.
- **Wrap-around:** stream 40 sequential pcs while accepting 1 or 2 per cycle at random.
  - Output order equals input order with no loss or duplication across pointer wrap `7→0`.
- **Flush collision:** count 5; in one cycle assert flush, a valid group and `accept = 11`.
  - Flush-cycle outputs are invalid.
  - Next cycle: count 0, outputs invalid, `stallreq = 0`.
- **Reset mid-operation:** count 6, `stallreq = 1`; assert `rst` between clock edges.
  - Outputs become invalid and `stallreq = 0` immediately, before the next edge.
  - After release, an enqueue behaves as in basic flow.
